mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly upstream of the MEM/WB register.
- Owns the data memory and performs byte, halfword and word stores from the EX/MEM outputs.
- Performs loads with sign or zero extension; its load result feeds the MEM/WB read-data input in the same cycle.
- After reset, runs a clear sequencer that zeroes the memory; provides an asynchronous debug read port for the debug unit.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/data_ram.sv | 45 ++++
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage of the MIPS pipeline.
// Contents:
//   MEM_BYTE / MEM_HALF / MEM_WORD - access-size encodings of i_mem_size
//   state_t (ST_CLEAR, ST_READY)   - memory-clear sequencer states
package mips_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/data_ram.sv
// Data memory of the MEM stage: 2**NB_ADDR words of NB_DATA bits.
// Ports:
//   clk            - clock
//   wr_en          - write strobe, committed on the rising edge
//   wr_be          - per-byte write enable (bit k covers bits [8k+7:8k])
//   wr_addr        - word index written
//   wr_data        - write data (only enabled lanes are stored)
//   rd_addr/rd_data   - asynchronous pipeline read port
//   dbg_addr/dbg_data - asynchronous debug read port
module data_ram #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 6
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [NB_DATA/8-1:0] wr_be,
  input  logic [NB_ADDR-1:0]   wr_addr,
  input  logic [NB_DATA-1:0]   wr_data,
  input  logic [NB_ADDR-1:0]   rd_addr,
  output logic [NB_DATA-1:0]   rd_data,
  input  logic [NB_ADDR-1:0]   dbg_addr,
  output logic [NB_DATA-1:0]   dbg_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_reg [0:DEPTH-1];

  // Single process for all lanes so the array has exactly one driver.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB_DATA / 8; b++) begin
        if (wr_be[b]) begin
          mem_reg[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Both reads are combinational: the load result must reach the MEM/WB
  // register in the same cycle, and the debug unit samples at will.
  assign rd_data  = mem_reg[rd_addr];
  assign dbg_data = mem_reg[dbg_addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Owns the data memory, performs byte/half/word stores, formats loads with
// sign or zero extension, and zeroes the whole memory after every reset
// before accepting stores.
// Ports:
//   i_clk, i_reset     - clock, synchronous active-high reset
//   i_dunit_clk_en     - pipeline step enable; 0 blocks stores
//   i_alu_res_ex_m     - byte address from EX/MEM
//   i_write_data       - store data (low bits used for sub-word stores)
//   i_mem_read/write   - load / store request
//   i_mem_size         - 00 byte, 01 half, 11 word (10 behaves as word)
//   i_mem_unsigned     - 1 zero-extends loads, 0 sign-extends
//   i_dunit_mem_addr   - debug word index
//   o_read_data        - formatted load data (combinational)
//   o_dunit_mem_data   - raw word at i_dunit_mem_addr (combinational)
//   o_misaligned       - current access is misaligned
//   o_mem_ready        - clear sequence finished
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int NB_REG    = 32,
  parameter int NB_ADDR_W = 6,
  parameter int NB_SIZE   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_dunit_clk_en,
  input  logic [NB_REG-1:0]    i_alu_res_ex_m,
  input  logic [NB_REG-1:0]    i_write_data,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [NB_SIZE-1:0]   i_mem_size,
  input  logic                 i_mem_unsigned,
  input  logic [NB_ADDR_W-1:0] i_dunit_mem_addr,
  output logic [NB_REG-1:0]    o_read_data,
  output logic [NB_REG-1:0]    o_dunit_mem_data,
  output logic                 o_misaligned,
  output logic                 o_mem_ready
);

  localparam int NB_LANE = NB_REG / 8;

  // ---------------- clear sequencer ----------------
  state_t                 state_reg, state_next;
  logic [NB_ADDR_W-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next = cnt_reg + NB_ADDR_W'(1);
        // The last word is written on the same edge that leaves CLEAR.
        if (cnt_reg == '1) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  logic clearing;
  logic ready;

  assign clearing    = (state_reg == ST_CLEAR);
  assign ready       = (state_reg == ST_READY);
  assign o_mem_ready = ready;

  // ---------------- address decode ----------------
  logic [1:0]           byte_idx;
  logic [NB_ADDR_W-1:0] word_idx;
  logic                 is_byte, is_half, is_word;
  logic                 unused_addr_bits;

  assign byte_idx = i_alu_res_ex_m[1:0];
  assign word_idx = i_alu_res_ex_m[NB_ADDR_W+1:2];
  // Upper address bits are deliberately dropped so accesses wrap.
  assign unused_addr_bits = ^i_alu_res_ex_m[NB_REG-1:NB_ADDR_W+2];

  assign is_byte = (i_mem_size == MEM_BYTE);
  assign is_half = (i_mem_size == MEM_HALF);
  // The reserved encoding 10 is handled exactly like a word access.
  assign is_word = ~is_byte & ~is_half;

  assign o_misaligned = (i_mem_read | i_mem_write) &
                        ((is_half & byte_idx[0]) | (is_word & (byte_idx != 2'b00)));

  // ---------------- store lanes ----------------
  logic [NB_LANE-1:0] lane_en;
  logic [NB_REG-1:0]  store_data;
  logic               store_en;

  genvar gi;
  generate
    for (gi = 0; gi < NB_LANE; gi++) begin : g_lane
      assign lane_en[gi] = is_word |
                           (is_half & (i_alu_res_ex_m[1] == 1'(gi / 2))) |
                           (is_byte & (byte_idx == 2'(gi)));
      // Sub-word data is replicated across lanes; the enables pick the target.
      assign store_data[8*gi +: 8] = is_byte ? i_write_data[7:0] :
                                     is_half ? i_write_data[8*(gi%2) +: 8] :
                                               i_write_data[8*gi +: 8];
    end
  endgenerate

  assign store_en = ready & i_dunit_clk_en & i_mem_write & ~o_misaligned & ~i_reset;

  // ---------------- memory ----------------
  logic                 ram_we;
  logic [NB_LANE-1:0]   ram_be;
  logic [NB_ADDR_W-1:0] ram_waddr;
  logic [NB_REG-1:0]    ram_wdata;
  logic [NB_REG-1:0]    rd_word;

  // While clearing, the sequencer owns the write port.
  assign ram_we    = clearing ? ~i_reset : store_en;
  assign ram_be    = clearing ? '1       : lane_en;
  assign ram_waddr = clearing ? cnt_reg  : word_idx;
  assign ram_wdata = clearing ? '0       : store_data;

  data_ram #(
    .NB_DATA (NB_REG),
    .NB_ADDR (NB_ADDR_W)
  ) u_data_ram (
    .clk      (i_clk),
    .wr_en    (ram_we),
    .wr_be    (ram_be),
    .wr_addr  (ram_waddr),
    .wr_data  (ram_wdata),
    .rd_addr  (word_idx),
    .rd_data  (rd_word),
    .dbg_addr (i_dunit_mem_addr),
    .dbg_data (o_dunit_mem_data)
  );

  // ---------------- load formatting ----------------
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rd_word[{byte_idx, 3'b000} +: 8];
  assign half_val = rd_word[{i_alu_res_ex_m[1], 4'b0000} +: 16];

  always_comb begin
    o_read_data = '0;
    if (ready & i_mem_read & ~o_misaligned) begin
      if (is_byte) begin
        o_read_data = {{(NB_REG-8){~i_mem_unsigned & byte_val[7]}}, byte_val};
      end else if (is_half) begin
        o_read_data = {{(NB_REG-16){~i_mem_unsigned & half_val[15]}}, half_val};
      end else begin
        o_read_data = rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd, wr;
  logic [1:0]  size;
  logic        uns;
  logic [5:0]  dbg_addr;
  logic [31:0] read_data, dbg_data;
  logic        misaligned, mem_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [0:63];

  always #5 clk = ~clk;

  mem_access_stage #(.NB_REG(32), .NB_ADDR_W(6), .NB_SIZE(2)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_dunit_clk_en   (clk_en),
    .i_alu_res_ex_m   (addr),
    .i_write_data     (wdata),
    .i_mem_read       (rd),
    .i_mem_write      (wr),
    .i_mem_size       (size),
    .i_mem_unsigned   (uns),
    .i_dunit_mem_addr (dbg_addr),
    .o_read_data      (read_data),
    .o_dunit_mem_data (dbg_data),
    .o_misaligned     (misaligned),
    .o_mem_ready      (mem_ready)
  );

  // ---------------- reference model ----------------
  function automatic logic model_misal(logic [31:0] a, logic [1:0] sz, logic r, logic w);
    if (!(r || w)) return 1'b0;
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] a,
                                             logic [1:0] sz, logic u);
    longint v;
    int     sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(a % 4);
      v  = longint'((word >> sh) & 32'hFF);
      if (!u && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      sh = 16 * int'((a % 4) / 2);
      v  = longint'((word >> sh) & 32'hFFFF);
      if (!u && v >= 32768) v = v - 65536;
    end else begin
      return word;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] a,
                                              logic [31:0] wd, logic [1:0] sz);
    logic [31:0] mask, val;
    int          sh;
    if (sz == 2'b00) begin
      sh   = 8 * int'(a % 4);
      mask = 32'hFF << sh;
      val  = (wd & 32'hFF) << sh;
    end else if (sz == 2'b01) begin
      sh   = 16 * int'((a % 4) / 2);
      mask = 32'hFFFF << sh;
      val  = (wd & 32'hFFFF) << sh;
    end else begin
      return wd;
    end
    return (old & ~mask) | val;
  endfunction

  task automatic set_idle();
    clk_en = 1'b1; addr = 32'h0; wdata = 32'h0; rd = 1'b0; wr = 1'b0;
    size = 2'b11; uns = 1'b0; dbg_addr = 6'd0;
  endtask

  task automatic set_acc(logic [31:0] a, logic [31:0] wd, logic r, logic w,
                         logic [1:0] sz, logic u, logic en);
    addr = a; wdata = wd; rd = r; wr = w; size = sz; uns = u; clk_en = en;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int zeros;
    @(negedge clk); set_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", mem_ready);
    end
    zeros = 0;
    while (mem_ready !== 1'b1 && zeros < 200) begin
      zeros++;
      @(negedge clk); #1;
    end
    checks++;
    if (zeros != 64) begin
      errors++; $display("FAIL clear_length: got %0d cycles want 64", zeros);
    end else
      $display("reset: clear took %0d cycles", zeros);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); dbg_addr = 6'(i); #1;
      checks++;
      if (dbg_data !== 32'h0) begin
        errors++; $display("FAIL clear_word[%0d]: got %h want 00000000", i, dbg_data);
      end
    end
    $display("reset: debug scan of 64 words done");
  endtask

  task automatic test_directed();
    logic [31:0] exp_b [3];
    logic [31:0] a_b   [3];
    logic        u_b   [3];
    // word store
    @(negedge clk); set_acc(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    @(negedge clk); set_acc(32'h10, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1); dbg_addr = 6'd4; #1;
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load: got %h want deadbeef", read_data);
    end
    checks++;
    if (dbg_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL dbg_word4: got %h want deadbeef", dbg_data);
    end
    $display("directed: word store/load at 0x10 -> %h", read_data);
    // byte loads
    a_b[0] = 32'h13; u_b[0] = 1'b0; exp_b[0] = 32'hFFFFFFDE;
    a_b[1] = 32'h13; u_b[1] = 1'b1; exp_b[1] = 32'h000000DE;
    a_b[2] = 32'h10; u_b[2] = 1'b0; exp_b[2] = 32'hFFFFFFEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_acc(a_b[i], 32'h0, 1'b1, 1'b0, 2'b00, u_b[i], 1'b1); #1;
      checks++;
      if (read_data !== exp_b[i]) begin
        errors++; $display("FAIL byte_load[%0d]: got %h want %h", i, read_data, exp_b[i]);
      end else
        $display("directed: byte load addr %h uns %b -> %h", a_b[i], u_b[i], read_data);
    end
    // half store
    @(negedge clk); set_acc(32'h12, 32'hAAAA1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_acc(32'h12, 32'h0, 1'b1, 1'b0, 2'b01, 1'(i), 1'b1); #1;
      checks++;
      if (dbg_data !== 32'h1234BEEF) begin
        errors++; $display("FAIL half_store_word: got %h want 1234beef", dbg_data);
      end
      checks++;
      if (read_data !== 32'h00001234) begin
        errors++; $display("FAIL half_load[uns=%0d]: got %h want 00001234", i, read_data);
      end else
        $display("directed: half load 0x12 uns %0d -> %h", i, read_data);
    end
    // read during write plus both read and write asserted
    @(negedge clk); set_acc(32'h10, 32'h55667788, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1); #1;
    checks++;
    if (read_data !== 32'h1234BEEF) begin
      errors++; $display("FAIL rdw_old: got %h want 1234beef", read_data);
    end
    @(negedge clk); set_acc(32'h10, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1); #1;
    checks++;
    if (read_data !== 32'h55667788) begin
      errors++; $display("FAIL rdw_new: got %h want 55667788", read_data);
    end else
      $display("directed: read-during-write old then new %h", read_data);
  endtask

  task automatic test_misaligned_blocked();
    // word store at 0x21 with a read
    @(negedge clk); set_acc(32'h21, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1); dbg_addr = 6'd8; #1;
    checks++;
    if (misaligned !== 1'b1) begin
      errors++; $display("FAIL mis_word: got %b want 1", misaligned);
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL mis_read_zero: got %h want 00000000", read_data);
    end
    @(negedge clk); set_idle(); dbg_addr = 6'd8; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL mis_word_unchanged: got %h want 00000000", dbg_data);
    end
    $display("misaligned: word store at 0x21 flagged and dropped");
    // half store at 0x11
    @(negedge clk); set_acc(32'h11, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1); dbg_addr = 6'd4; #1;
    checks++;
    if (misaligned !== 1'b1) begin
      errors++; $display("FAIL mis_half: got %b want 1", misaligned);
    end
    // blocked by clk_en=0
    @(negedge clk); set_acc(32'h10, 32'h0BADF00D, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0); dbg_addr = 6'd4;
    @(negedge clk); set_idle(); dbg_addr = 6'd4; #1;
    checks++;
    if (dbg_data !== 32'h55667788) begin
      errors++; $display("FAIL blocked_unchanged: got %h want 55667788", dbg_data);
    end
    $display("blocked: misaligned half and clk_en=0 stores dropped, word4=%h", dbg_data);
  endtask

  task automatic test_reset_mid_clear();
    int zeros;
    @(negedge clk); set_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_acc(32'h10, 32'hCAFEF00D, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1); #1;
    zeros = 0;
    while (mem_ready !== 1'b1 && zeros < 200) begin
      checks++;
      if (read_data !== 32'h0) begin
        errors++; $display("FAIL clear_read_zero: got %h want 00000000", read_data);
      end
      zeros++;
      @(negedge clk); #1;
    end
    checks++;
    if (zeros != 64) begin
      errors++; $display("FAIL restart_clear_length: got %0d cycles want 64", zeros);
    end else
      $display("reset mid-clear: clear restarted, %0d cycles", zeros);
    // first READY cycle: this store commits on the next edge
    set_acc(32'h20, 32'h13579BDF, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    @(negedge clk); set_idle(); dbg_addr = 6'd8; #1;
    checks++;
    if (dbg_data !== 32'h13579BDF) begin
      errors++; $display("FAIL first_store: got %h want 13579bdf", dbg_data);
    end
    dbg_addr = 6'd4; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++; $display("FAIL store_before_ready: got %h want 00000000", dbg_data);
    end
    $display("store before ready dropped, first ready store committed");
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_mem[8] = 32'h13579BDF;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, prev_a, exp_rd, word;
    logic [1:0]  sz;
    logic        r, w, u, en, exp_mis;
    int          idx, di, nerr;
    prev_a = 32'h0;
    for (int t = 0; t < 400; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? prev_a : $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b01) a = a & ~32'h1;
        else if (sz != 2'b00) a = a & ~32'h3;
      end
      wd = $urandom;
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      di = $urandom_range(0, 63);
      @(negedge clk); set_acc(a, wd, r, w, sz, u, en); dbg_addr = 6'(di); #1;
      idx     = int'((a / 4) % 64);
      word    = model_mem[idx];
      exp_mis = model_misal(a, sz, r, w);
      exp_rd  = (r && !exp_mis) ? model_load(word, a, sz, u) : 32'h0;
      nerr = errors;
      checks++;
      if (misaligned !== exp_mis) begin
        errors++; $display("FAIL rnd_mis[%0d]: got %b want %b", t, misaligned, exp_mis);
      end
      checks++;
      if (read_data !== exp_rd) begin
        errors++; $display("FAIL rnd_load[%0d]: addr %h sz %b u %b got %h want %h",
                           t, a, sz, u, read_data, exp_rd);
      end
      checks++;
      if (dbg_data !== model_mem[di]) begin
        errors++; $display("FAIL rnd_dbg[%0d]: idx %0d got %h want %h", t, di, dbg_data, model_mem[di]);
      end
      if (errors == nerr)
        $display("rnd %0d: addr %h sz %b r%b w%b en%b -> rd %h mis %b", t, a, sz, r, w, en, read_data, misaligned);
      if (w && en && !exp_mis) model_mem[idx] = model_store(word, a, wd, sz);
      prev_a = a;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_directed();
    test_misaligned_blocked();
    test_reset_mid_clear();
    test_random();
    @(negedge clk); set_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
